// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared widths, FSM state type and address helper for the load/store unit.
//   FULLW       data/address word width
//   LSU_SW      state encoding width
//   lsu_state_t IDLE / RD_WAIT / WR / RESP
//   word_align  clears the two byte-offset bits of an address
package mem_lsu_pkg;
   localparam int FULLW = 32;
   localparam int LSU_SW = 2;
   typedef enum logic [LSU_SW-1:0] {LSU_IDLE, LSU_RD_WAIT, LSU_WR, LSU_RESP} lsu_state_t;
   function automatic logic [FULLW-1:0] word_align(input logic [FULLW-1:0] a);
      return {a[FULLW-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/mem_lsu_byte_lane.sv
// mem_lsu_byte_lane: big-endian byte extract/merge for one 32-bit word.
//   i_word   word read from RAM
//   i_lane   byte offset within the word (0 = most significant byte)
//   i_byte   byte to insert
//   o_byte   byte at i_lane of i_word
//   o_merged i_word with i_lane replaced by i_byte
module mem_lsu_byte_lane
   import mem_lsu_pkg::*;
(
   input  logic [FULLW-1:0] i_word,
   input  logic [1:0]       i_lane,
   input  logic [7:0]       i_byte,
   output logic [7:0]       o_byte,
   output logic [FULLW-1:0] o_merged
);
   logic [4:0] w_sh;
   // lane k lives at bit (3-k)*8; for a 2-bit lane, 3-k is simply ~k
   assign w_sh = {~i_lane, 3'b000};
   assign o_byte = 8'(i_word >> w_sh);
   assign o_merged = (i_word & ~(FULLW'(8'hFF) << w_sh)) | (FULLW'(i_byte) << w_sh);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the byte-addressed data RAM (word/byte loads, word stores, byte stores via RMW).
//   clk, rst_n                   clock, async active-low reset
//   i_req_valid/o_req_ready      request handshake (ready only in IDLE)
//   i_req_write, i_req_byte      store/load, byte/word
//   i_req_addr, i_req_wdata      byte address, store data (byte store uses [7:0])
//   o_resp_valid/err/rdata       registered one-cycle completion pulse
//   o_ram_wa/wd/we, o_ram_ra     RAM write and read ports (always word-aligned)
//   i_ram_out                    registered RAM read data
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic             i_req_write,
   input  logic             i_req_byte,
   input  logic [FULLW-1:0] i_req_addr,
   input  logic [FULLW-1:0] i_req_wdata,
   output logic             o_resp_valid,
   output logic             o_resp_err,
   output logic [FULLW-1:0] o_resp_rdata,
   output logic [FULLW-1:0] o_ram_wa,
   output logic [FULLW-1:0] o_ram_wd,
   output logic             o_ram_we,
   output logic [FULLW-1:0] o_ram_ra,
   input  logic [FULLW-1:0] i_ram_out
);
   lsu_state_t       r_state;
   logic [FULLW-1:0] r_addr;
   logic [FULLW-1:0] r_wd;
   logic [1:0]       r_lane;
   logic             r_write;
   logic             r_byte;
   logic             w_accept;
   logic             w_err;
   logic [7:0]       w_byte;
   logic [FULLW-1:0] w_merged;

   mem_lsu_byte_lane u_lane (
      .i_word   (i_ram_out),
      .i_lane   (r_lane),
      .i_byte   (r_wd[7:0]),
      .o_byte   (w_byte),
      .o_merged (w_merged)
   );

   assign o_req_ready = r_state == LSU_IDLE;
   assign w_accept = i_req_valid & o_req_ready;
   assign w_err = (~i_req_byte & |i_req_addr[1:0]) | ((i_req_addr >> ADDR_WIDTH) != '0);
   // speculative read in IDLE so ram_out is ready the cycle after accept
   assign o_ram_ra = o_req_ready ? word_align(i_req_addr) : r_addr;
   assign o_ram_we = r_state == LSU_WR;
   assign o_ram_wa = r_addr;
   assign o_ram_wd = r_wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LSU_IDLE;
         r_addr       <= '0;
         r_wd         <= '0;
         r_lane       <= '0;
         r_write      <= 1'b0;
         r_byte       <= 1'b0;
         o_resp_valid <= 1'b0;
         o_resp_err   <= 1'b0;
         o_resp_rdata <= '0;
      end else begin
         case (r_state)
            LSU_IDLE: if (w_accept) begin
               r_addr  <= word_align(i_req_addr);
               r_lane  <= i_req_addr[1:0];
               r_write <= i_req_write;
               r_byte  <= i_req_byte;
               r_wd    <= i_req_wdata;
               if (w_err) begin
                  r_state      <= LSU_RESP;
                  o_resp_valid <= 1'b1;
                  o_resp_err   <= 1'b1;
               end else begin
                  r_state <= (i_req_write & ~i_req_byte) ? LSU_WR : LSU_RD_WAIT;
               end
            end
            LSU_RD_WAIT: if (r_write) begin
               r_wd    <= w_merged;
               r_state <= LSU_WR;
            end else begin
               o_resp_rdata <= r_byte ? {24'b0, w_byte} : i_ram_out;
               o_resp_valid <= 1'b1;
               r_state      <= LSU_RESP;
            end
            LSU_WR: begin
               o_resp_valid <= 1'b1;
               r_state      <= LSU_RESP;
            end
            default: begin
               o_resp_valid <= 1'b0;
               o_resp_err   <= 1'b0;
               o_resp_rdata <= '0;
               r_state      <= LSU_IDLE;
            end
         endcase
      end
   end
endmodule
